// File: rtl/stream_pkg.sv
// Shared definitions for the stream demux: slot state encoding, counter limits
// and a constant clog2 used to size the channel select.
package stream_pkg;

    typedef logic [0:0] slot_state_t;

    localparam slot_state_t SLOT_EMPTY = 1'b0;
    localparam slot_state_t SLOT_FULL  = 1'b1;

    localparam logic [7:0] DROP_MAX = 8'hFF;

    // Ceiling log2 with a floor of 1 so a select port always has at least one bit.
    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v = value - 1;
        while (v > 0) begin
            result = result + 1;
            v = v >> 1;
        end
        if (result < 1) result = 1;
        return result;
    endfunction

endpackage

// File: rtl/demux_slot.sv
// One output channel of the demux: a one-deep register slot with EMPTY/FULL state.
// A load while FULL is only issued by the parent when the slot unloads the same cycle.
module demux_slot
    import stream_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             out_ready,
    output slot_state_t      state,
    output logic [WIDTH-1:0] data
);

    slot_state_t      state_q;
    logic [WIDTH-1:0] data_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= SLOT_EMPTY;
            data_q  <= '0;
        end else begin
            if (load) begin
                state_q <= SLOT_FULL;
                data_q  <= load_data;
            end else if (state_q == SLOT_FULL && out_ready) begin
                // data_q keeps its last value after draining
                state_q <= SLOT_EMPTY;
            end
        end
    end

    assign state = state_q;
    assign data  = data_q;

endmodule

// File: rtl/stream_demux.sv
// Routes one upstream valid/ready stream to CHANNELS independent one-deep output slots;
// words addressed beyond the last channel are accepted, discarded and counted.
module stream_demux
    import stream_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4,
    localparam int SEL_W   = clog2(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [WIDTH-1:0]          in_data,
    input  logic [SEL_W-1:0]          in_sel,
    output logic [CHANNELS-1:0]       out_valid,
    input  logic [CHANNELS-1:0]       out_ready,
    output logic [WIDTH*CHANNELS-1:0] out_data,
    output logic [7:0]                drop_count
);

    // Handshake: a word moves when valid && ready at a rising edge; ready never
    // looks at valid, and a valid word is held stable by its source until it moves.

    localparam logic [SEL_W:0] CH_LIMIT = CHANNELS[SEL_W:0];

    logic                sel_in_range;
    logic                sel_blocked;
    logic                accept;
    logic                drop_event;
    logic [CHANNELS-1:0] sel_onehot;
    logic [CHANNELS-1:0] slot_load;
    slot_state_t         slot_state [CHANNELS];

    assign sel_in_range = ({1'b0, in_sel} < CH_LIMIT);

    always_comb begin
        sel_blocked = 1'b0;
        sel_onehot  = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            if (in_sel == SEL_W'(k)) begin
                sel_onehot[k] = 1'b1;
                sel_blocked   = out_valid[k] && !out_ready[k];
            end
        end
    end

    // Out-of-range selects are always takeable so the stream never wedges on them.
    assign in_ready   = !rst && (!sel_in_range || !sel_blocked);
    assign accept     = in_valid && in_ready;
    assign slot_load  = sel_onehot & {CHANNELS{accept}};
    assign drop_event = accept && !sel_in_range;

    for (genvar k = 0; k < CHANNELS; k++) begin : g_slot
        demux_slot #(
            .WIDTH (WIDTH)
        ) u_slot (
            .clk       (clk),
            .rst       (rst),
            .load      (slot_load[k]),
            .load_data (in_data),
            .out_ready (out_ready[k]),
            .state     (slot_state[k]),
            .data      (out_data[k*WIDTH +: WIDTH])
        );
        assign out_valid[k] = (slot_state[k] == SLOT_FULL);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drop_count <= '0;
        end else if (drop_event && drop_count != DROP_MAX) begin
            drop_count <= drop_count + 8'd1;
        end
    end

endmodule
